burst_ram_arbiter: RTL and testbench

Two-client arbiter between cache-side burst masters and the single BurstRAM command port. Typical clients are the instruction and data caches, or two Cache instances. Each client sees a BurstRAM-compatible interface. The block buffers one full request per client, including the whole write burst, and issues requests round-robin. Read bursts are steered back to the issuing client only.

---
 rtl/burst_ram_arbiter_if.sv | 22 ++
 rtl/burst_ram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if -- one BurstRAM-style command port.
// master: the side that issues commands (a cache, or the arbiter toward the RAM).
// slave:  the side that serves them (the RAM, or the arbiter toward a client).
interface burst_ram_arbiter_if #(
   parameter int DATA_BITWIDTH  = 64,
   parameter int DEPTH_BITWIDTH = 8,
   parameter int MASK_BITWIDTH  = DATA_BITWIDTH / 8
);
   logic                      cmd;
   logic                      cmd_en;
   logic [DEPTH_BITWIDTH-1:0] addr;
   logic [DATA_BITWIDTH-1:0]  wr_data;
   logic [MASK_BITWIDTH-1:0]  data_mask;
   logic [DATA_BITWIDTH-1:0]  rd_data;
   logic                      rd_data_valid;
   logic                      busy;

   modport master (output cmd, cmd_en, addr, wr_data, data_mask,
                   input  rd_data, rd_data_valid, busy);
   modport slave  (input  cmd, cmd_en, addr, wr_data, data_mask,
                   output rd_data, rd_data_valid, busy);
endinterface

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter -- two-client round-robin arbiter in front of one BurstRAM.
// Each client slot holds one full request (whole write burst included); read
// words are steered back to the client that owns the in-flight read.
// Optional: define BURST_ARBITER_STATS_EN to add 16-bit saturating grant counters.
module burst_ram_arbiter #(
   parameter int DATA_BITWIDTH  = 64,
   parameter int DEPTH_BITWIDTH = 8,
   parameter int BURST_COUNT    = 4
) (
   input  logic                clk,
   input  logic                rst,
   burst_ram_arbiter_if.slave  a,
   burst_ram_arbiter_if.slave  b,
   burst_ram_arbiter_if.master br
`ifdef BURST_ARBITER_STATS_EN
   ,
   output logic [15:0]         a_grant_count,
   output logic [15:0]         b_grant_count
`endif
);
   localparam int MASK_BITWIDTH = DATA_BITWIDTH / 8;
   localparam int CW = $clog2(BURST_COUNT);      // word index width
   localparam int RW = $clog2(BURST_COUNT + 1);  // forwarded read word count width

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
   state_t state, state_nx;

   // client inputs indexed by client (0 = A, 1 = B)
   logic [1:0]                     c_cmd, c_cmd_en;
   logic [1:0][DEPTH_BITWIDTH-1:0] c_addr;
   logic [1:0][DATA_BITWIDTH-1:0]  c_wr_data;
   logic [1:0][MASK_BITWIDTH-1:0]  c_mask;

   // per-client request slots
   logic [1:0]                                     s_busy, s_pend, s_fill, s_cmd;
   logic [1:0][CW-1:0]                             s_fcnt;
   logic [1:0][DEPTH_BITWIDTH-1:0]                 s_addr;
   logic [1:0][MASK_BITWIDTH-1:0]                  s_mask;
   logic [1:0][BURST_COUNT-1:0][DATA_BITWIDTH-1:0] s_buf;

   logic          ptr, owner, win, grant, done, beat_last, fwd;
   logic [CW-1:0] beat;
   logic [RW-1:0] rd_cnt;

   logic                      br_cmd_q, br_cmd_en_q;
   logic [DEPTH_BITWIDTH-1:0] br_addr_q;
   logic [DATA_BITWIDTH-1:0]  br_wr_data_q;
   logic [MASK_BITWIDTH-1:0]  br_mask_q;

   assign c_cmd     = {b.cmd, a.cmd};
   assign c_cmd_en  = {b.cmd_en, a.cmd_en};
   assign c_addr    = {b.addr, a.addr};
   assign c_wr_data = {b.wr_data, a.wr_data};
   assign c_mask    = {b.data_mask, a.data_mask};

   // Slot capture: word 0 with the command, remaining write words stream in behind it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            s_busy[i] <= 1'b0;
            s_pend[i] <= 1'b0;
            s_fill[i] <= 1'b0;
            s_fcnt[i] <= '0;
         end else if (done && owner == 1'(i)) begin
            s_busy[i] <= 1'b0;
            s_pend[i] <= 1'b0;
         end else if (!s_busy[i]) begin
            if (c_cmd_en[i]) begin
               s_busy[i]     <= 1'b1;
               s_cmd[i]      <= c_cmd[i];
               s_addr[i]     <= c_addr[i];
               s_mask[i]     <= c_mask[i];
               s_buf[i][0]   <= c_wr_data[i];
               s_pend[i]     <= !c_cmd[i];
               s_fill[i]     <= c_cmd[i];
               s_fcnt[i]     <= CW'(1);
            end
         end else if (s_fill[i]) begin
            s_buf[i][s_fcnt[i]] <= c_wr_data[i];
            s_fcnt[i]           <= s_fcnt[i] + 1'b1;
            if (s_fcnt[i] == CW'(BURST_COUNT - 1)) begin
               s_fill[i] <= 1'b0;
               s_pend[i] <= 1'b1;
            end
         end
      end
   end

   // Winner: the pointer client when both are pending, otherwise whichever is pending.
   always_comb begin
      win = ptr;
      if (s_pend[0] && !s_pend[1])      win = 1'b0;
      else if (s_pend[1] && !s_pend[0]) win = 1'b1;
   end

   assign grant     = (state == IDLE) && (|s_pend) && !br.busy;
   assign beat_last = !s_cmd[owner] || (beat == CW'(BURST_COUNT - 1));
   assign fwd       = !rst && br.rd_data_valid && (state != IDLE) && !s_cmd[owner];
   assign done      = (state == WAIT_DONE) && !br.busy &&
                      (s_cmd[owner] || rd_cnt == RW'(BURST_COUNT));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: ISSUE spans one cycle for a read, the whole burst for a write.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (grant) state_nx = ISSUE;
         ISSUE:      if (beat_last) state_nx = WAIT_START;
         WAIT_START: state_nx = WAIT_DONE;
         WAIT_DONE:  if (done) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // Registered BurstRAM command/data, owner tracking and read word counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= 1'b0;
         owner        <= 1'b0;
         beat         <= '0;
         rd_cnt       <= '0;
         br_cmd_q     <= 1'b0;
         br_cmd_en_q  <= 1'b0;
         br_addr_q    <= '0;
         br_wr_data_q <= '0;
         br_mask_q    <= '0;
      end else begin
         br_cmd_en_q <= 1'b0;
         if (grant) begin
            owner        <= win;
            beat         <= '0;
            rd_cnt       <= '0;
            br_cmd_en_q  <= 1'b1;
            br_cmd_q     <= s_cmd[win];
            br_addr_q    <= s_addr[win];
            br_mask_q    <= s_mask[win];
            br_wr_data_q <= s_buf[win][0];
         end else if (state == ISSUE && !beat_last) begin
            beat         <= beat + 1'b1;
            br_wr_data_q <= s_buf[owner][beat + 1'b1];
         end
         if (fwd)  rd_cnt <= rd_cnt + 1'b1;
         if (done) ptr    <= ~owner;
      end
   end

   assign br.cmd       = br_cmd_q;
   assign br.cmd_en    = br_cmd_en_q;
   assign br.addr      = br_addr_q;
   assign br.wr_data   = br_wr_data_q;
   assign br.data_mask = br_mask_q;

   assign a.rd_data       = rst ? '0 : br.rd_data;
   assign b.rd_data       = rst ? '0 : br.rd_data;
   assign a.rd_data_valid = fwd && (owner == 1'b0);
   assign b.rd_data_valid = fwd && (owner == 1'b1);
   assign a.busy          = rst | s_busy[0];
   assign b.busy          = rst | s_busy[1];

`ifdef BURST_ARBITER_STATS_EN
   // Grant counters step on the command cycle of their client and stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_grant_count <= '0;
         b_grant_count <= '0;
      end else if (br_cmd_en_q) begin
         if (!owner && a_grant_count != 16'hFFFF) a_grant_count <= a_grant_count + 1'b1;
         if (owner && b_grant_count != 16'hFFFF)  b_grant_count <= b_grant_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter -- directed bench with a BurstRAM model (3-cycle read latency,
// 4-word bursts); expected commands and read words are queued by the stimulus and
// checked by an independent monitor.
`timescale 1ns/1ps
module tb_burst_ram_arbiter;
   localparam int DW = 64, AW = 8, BC = 4, MW = 8, DLY = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   burst_ram_arbiter_if #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW)) a_if ();
   burst_ram_arbiter_if #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW)) b_if ();
   burst_ram_arbiter_if #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW)) br_if ();

`ifdef BURST_ARBITER_STATS_EN
   logic [15:0] a_gc, b_gc;
`endif

   burst_ram_arbiter #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW), .BURST_COUNT(BC)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a_if),
      .b   (b_if),
      .br  (br_if)
`ifdef BURST_ARBITER_STATS_EN
      ,
      .a_grant_count (a_gc),
      .b_grant_count (b_gc)
`endif
   );

   typedef struct {
      logic          cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] w0;
   } exp_cmd_t;

   exp_cmd_t      exp_cmd [$];
   logic [DW-1:0] exp_a [$];
   logic [DW-1:0] exp_b [$];
   int total = 0;
   int bad   = 0;

   function automatic logic [DW-1:0] ramw(int i);
      return 64'hC0DE_0000_0000_0000 | 64'(i);
   endfunction

   function automatic logic [DW-1:0] mrg(logic [DW-1:0] o, logic [DW-1:0] n, logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = o;
      for (int k = 0; k < MW; k++) if (m[k]) r[8*k +: 8] = n[8*k +: 8];
      return r;
   endfunction

   // BurstRAM model
   logic [DW-1:0] mem [256];
   logic          m_init = 1'b0, m_busy = 1'b0, m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   int            m_cnt = 0;
   assign br_if.busy = m_busy;

   always @(posedge clk) begin
      br_if.rd_data_valid <= 1'b0;
      if (!m_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= ramw(i);
         m_init <= 1'b1;
      end
      if (!m_busy) begin
         if (br_if.cmd_en) begin
            m_busy <= 1'b1;
            m_wr   <= br_if.cmd;
            m_addr <= br_if.addr;
            m_cnt  <= 1;
            if (br_if.cmd) mem[br_if.addr] <= mrg(mem[br_if.addr], br_if.wr_data, br_if.data_mask);
         end
      end else if (m_wr) begin
         mem[m_addr + AW'(m_cnt)] <= mrg(mem[m_addr + AW'(m_cnt)], br_if.wr_data, br_if.data_mask);
         m_cnt <= m_cnt + 1;
         if (m_cnt == BC - 1) m_busy <= 1'b0;
      end else begin
         if (m_cnt + 1 >= DLY && m_cnt + 1 < DLY + BC) begin
            br_if.rd_data_valid <= 1'b1;
            br_if.rd_data       <= mem[m_addr + AW'(m_cnt + 1 - DLY)];
         end
         if (m_cnt + 1 == DLY + BC) m_busy <= 1'b0;
         m_cnt <= m_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit cl, input bit en, input bit wr, input logic [AW-1:0] ad,
                        input logic [DW-1:0] d);
      if (!cl) begin
         a_if.cmd_en = en; a_if.cmd = wr; a_if.addr = ad; a_if.wr_data = d; a_if.data_mask = '1;
      end else begin
         b_if.cmd_en = en; b_if.cmd = wr; b_if.addr = ad; b_if.wr_data = d; b_if.data_mask = '1;
      end
   endtask

   // queue one read: command plus the four words the RAM pattern holds there
   task automatic exp_read(input bit cl, input logic [AW-1:0] ad);
      exp_cmd_t e;
      e.cmd = 1'b0; e.addr = ad; e.w0 = '0;
      exp_cmd.push_back(e);
      for (int k = 0; k < BC; k++) begin
         if (!cl) exp_a.push_back(ramw(int'(ad) + k));
         else     exp_b.push_back(ramw(int'(ad) + k));
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((a_if.busy || b_if.busy) && n < 300) begin
         cyc();
         n++;
      end
      total++;
      if (n >= 300) begin
         bad++;
         $display("FAIL %s: busy still high after %0d cycles, want low", nm, n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc();
   endtask

   // Monitor: every valid word / command the DUT presents is matched against the queues.
   exp_cmd_t      me;
   logic [DW-1:0] mw;
   always @(negedge clk) begin
      if (!rst) begin
         if (a_if.rd_data_valid) begin
            if (exp_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_rd_unexpected: got word %h, want no valid", a_if.rd_data);
            end else begin
               mw = exp_a.pop_front();
               chk("a_rd_data", a_if.rd_data, mw);
            end
         end
         if (b_if.rd_data_valid) begin
            if (exp_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_rd_unexpected: got word %h, want no valid", b_if.rd_data);
            end else begin
               mw = exp_b.pop_front();
               chk("b_rd_data", b_if.rd_data, mw);
            end
         end
         if (br_if.cmd_en) begin
            if (exp_cmd.size() == 0) begin
               total++; bad++;
               $display("FAIL br_cmd_unexpected: got addr %h, want no command", br_if.addr);
            end else begin
               me = exp_cmd.pop_front();
               chk("br_cmd", 64'(br_if.cmd), 64'(me.cmd));
               chk("br_addr", 64'(br_if.addr), 64'(me.addr));
               if (me.cmd) chk("br_wr_word0", br_if.wr_data, me.w0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      logic [3:0][DW-1:0] wd;
      exp_cmd_t e;
      int na, nb, c, v;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);

      // 1: reset
      cyc(2);
      chk("rst_a_busy", 64'(a_if.busy), 64'd1);
      chk("rst_b_busy", 64'(b_if.busy), 64'd1);
      chk("rst_br_cmd_en", 64'(br_if.cmd_en), 64'd0);
      rst = 1'b0;
      cyc();
      chk("post_rst_a_busy", 64'(a_if.busy), 64'd0);
      chk("post_rst_b_busy", 64'(b_if.busy), 64'd0);
      chk("post_rst_br_cmd_en", 64'(br_if.cmd_en), 64'd0);

      // 2: single A read at 8, latency T+2
      exp_read(0, 8'd8);
      drive(0, 1, 0, 8'd8, '0);
      cyc();
      drive(0, 0, 0, '0, '0);
      chk("rd_lat_t1", 64'(br_if.cmd_en), 64'd0);
      cyc();
      chk("rd_lat_t2", 64'(br_if.cmd_en), 64'd1);
      wait_idle("t2_idle");

      // 3: simultaneous reads after reset, A first
      do_reset();
      exp_read(0, 8'd4);
      exp_read(1, 8'd16);
      drive(0, 1, 0, 8'd4, '0);
      drive(1, 1, 0, 8'd16, '0);
      cyc();
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      cyc();
      wait_idle("t3_idle");

      // 4: B write at 20, then A reads it back
      wd[0] = 64'h1111111111111111; wd[1] = 64'h2222222222222222;
      wd[2] = 64'h3333333333333333; wd[3] = 64'h4444444444444444;
      e.cmd = 1'b1; e.addr = 8'd20; e.w0 = wd[0];
      exp_cmd.push_back(e);
      drive(1, 1, 1, 8'd20, wd[0]);
      for (int k = 1; k < BC; k++) begin
         cyc();
         drive(1, 0, 1, 8'd20, wd[k]);
      end
      cyc();
      chk("wr_lat_t4", 64'(br_if.cmd_en), 64'd0);
      cyc();
      chk("wr_lat_t5", 64'(br_if.cmd_en), 64'd1);
      cyc();
      chk("wr_word1", br_if.wr_data, wd[1]);
      wait_idle("t4_wr_idle");
      e.cmd = 1'b0; e.addr = 8'd20; e.w0 = '0;
      exp_cmd.push_back(e);
      for (int k = 0; k < BC; k++) exp_a.push_back(wd[k]);
      drive(0, 1, 0, 8'd20, '0);
      cyc();
      drive(0, 0, 0, '0, '0);
      cyc();
      wait_idle("t4_rd_idle");

      // 5: back-to-back requests, alternating grants
      do_reset();
      for (int k = 0; k < 4; k++) begin
         exp_read(0, 8'(32 + 4 * k));
         exp_read(1, 8'(64 + 4 * k));
      end
      na = 0; nb = 0; c = 0;
      while ((na < 4 || nb < 4 || a_if.busy || b_if.busy) && c < 2000) begin
         if (!a_if.busy && na < 4) begin drive(0, 1, 0, 8'(32 + 4 * na), '0); na++; end
         else drive(0, 0, 0, '0, '0);
         if (!b_if.busy && nb < 4) begin drive(1, 1, 0, 8'(64 + 4 * nb), '0); nb++; end
         else drive(1, 0, 0, '0, '0);
         cyc();
         c++;
      end
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      chk("t5_requests_done", 64'(na + nb), 64'd8);
`ifdef BURST_ARBITER_STATS_EN
      chk("a_grant_count", 64'(a_gc), 64'd4);
      chk("b_grant_count", 64'(b_gc), 64'd4);
`endif

      // 6: reset during the second word of an A read
      e.cmd = 1'b0; e.addr = 8'd40; e.w0 = '0;
      exp_cmd.push_back(e);
      exp_a.push_back(ramw(40));
      drive(0, 1, 0, 8'd40, '0);
      cyc();
      drive(0, 0, 0, '0, '0);
      v = 0;
      while (!a_if.rd_data_valid && v < 50) begin
         cyc();
         v++;
      end
      chk("t6_first_valid_seen", 64'(a_if.rd_data_valid), 64'd1);
      cyc();
      rst = 1'b1;
      cyc();
      chk("t6_rst_a_busy", 64'(a_if.busy), 64'd1);
      chk("t6_rst_br_cmd_en", 64'(br_if.cmd_en), 64'd0);
      chk("t6_rst_a_valid", 64'(a_if.rd_data_valid), 64'd0);
      chk("t6_rst_a_rd_data", a_if.rd_data, 64'd0);
      rst = 1'b0;
      cyc();
      chk("t6_post_a_busy", 64'(a_if.busy), 64'd0);
      exp_read(1, 8'd0);
      drive(1, 1, 0, 8'd0, '0);
      cyc();
      drive(1, 0, 0, '0, '0);
      cyc();
      wait_idle("t6_idle");
      cyc(4);

      chk("exp_cmd_left", 64'(exp_cmd.size()), 64'd0);
      chk("exp_a_left", 64'(exp_a.size()), 64'd0);
      chk("exp_b_left", 64'(exp_b.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
